mem_rd_port: RTL and testbench

Read-side controller for the accumulator CPU's synchronous data memory. On a one-cycle `start` from the microcode sequencer, it presents an address and holds the read strobe through a fixed number of wait states. It waits for the memory's ready and captures the returned word into an output holding register. It signals completion with a single-cycle `done`. It sits between the sequencer and the data memory, and it is the counterpart to the enable-gated storage registers that write results back.

---
 rtl/mem_rd_port.sv | 113 +++++++++++
 tb/tb_mem_rd_port.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_port.sv
// Read-side memory port: strobes a registered address through WAIT wait states and captures data on mem_rdy.
// Optional: define MEM_RD_TIMEOUT_EN to abort a read after 16 consecutive stall cycles with an err pulse.
module mem_rd_port #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 8,
   parameter int WAIT   = 1
) (
   input  logic              clk,
   input  logic              res,
   input  logic              start,
   input  logic [AWIDTH-1:0] addr,
   output logic [AWIDTH-1:0] mem_a,
   output logic              mem_rd,
   input  logic [DWIDTH-1:0] mem_d,
   input  logic              mem_rdy,
   output logic [DWIDTH-1:0] Q,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_SAMPLE} state_t;

   localparam logic [3:0] WAIT_LD = 4'(WAIT);

   state_t            state_q;
   logic [3:0]        waitCnt_q;
   logic [AWIDTH-1:0] memA_q;
   logic              memRd_q;
   logic [DWIDTH-1:0] data_q;
   logic              done_q;

`ifdef MEM_RD_TIMEOUT_EN
   logic [3:0] stallCnt_q;
   logic       err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign mem_a  = memA_q;
   assign mem_rd = memRd_q;
   assign Q      = data_q;
   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;

   // An aborted read leaves data_q untouched except for the reset clear.
   always_ff @(posedge clk) begin
      if (res) begin
         state_q   <= S_IDLE;
         waitCnt_q <= '0;
         memA_q    <= '0;
         memRd_q   <= 1'b0;
         data_q    <= '0;
         done_q    <= 1'b0;
`ifdef MEM_RD_TIMEOUT_EN
         stallCnt_q <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
`ifdef MEM_RD_TIMEOUT_EN
         err_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  memA_q  <= addr;
                  state_q <= S_ADDR;
               end
            end
            S_ADDR: begin
               memRd_q   <= 1'b1;
               waitCnt_q <= WAIT_LD;
`ifdef MEM_RD_TIMEOUT_EN
               stallCnt_q <= '0;
`endif
               if (WAIT == 0) begin
                  state_q <= S_SAMPLE;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               waitCnt_q <= waitCnt_q - 4'd1;
               if (waitCnt_q <= 4'd1) begin
                  state_q <= S_SAMPLE;
               end
            end
            S_SAMPLE: begin
               if (mem_rdy) begin
                  data_q  <= mem_d;
                  done_q  <= 1'b1;
                  memRd_q <= 1'b0;
                  state_q <= S_IDLE;
`ifdef MEM_RD_TIMEOUT_EN
               end else if (stallCnt_q == 4'hF) begin
                  err_q   <= 1'b1;
                  memRd_q <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  stallCnt_q <= stallCnt_q + 4'd1;
`endif
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_rd_port.sv
// Testbench for mem_rd_port: three instances with WAIT = 1, 0 and 3, each checked
// against a cycle timeline derived from the read protocol (plus timeout when MEM_RD_TIMEOUT_EN).
module tb_mem_rd_port;

   localparam int NDUT = 3;
   localparam int WAITS [NDUT] = '{1, 0, 3};

   logic       clk = 1'b0;
   logic       res    [NDUT];
   logic       start  [NDUT];
   logic [7:0] addr   [NDUT];
   logic [7:0] memD   [NDUT];
   logic       memRdy [NDUT];
   logic [7:0] memA   [NDUT];
   logic       memRd  [NDUT];
   logic [7:0] q      [NDUT];
   logic       busy   [NDUT];
   logic       done   [NDUT];
   logic       err    [NDUT];
   logic [7:0] lastQ  [NDUT];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      mem_rd_port #(.DWIDTH(8), .AWIDTH(8), .WAIT(WAITS[g])) dut (
         .clk     (clk),
         .res     (res[g]),
         .start   (start[g]),
         .addr    (addr[g]),
         .mem_a   (memA[g]),
         .mem_rd  (memRd[g]),
         .mem_d   (memD[g]),
         .mem_rdy (memRdy[g]),
         .Q       (q[g]),
         .busy    (busy[g]),
         .done    (done[g]),
         .err     (err[g])
      );
   end

   // Reset with start held high and random inputs: everything clears and nothing is accepted.
   task automatic test_reset();
      for (int i = 0; i < NDUT; i++) begin
         res[i] = 1'b1; start[i] = 1'b1;
         addr[i] = 8'($urandom); memD[i] = 8'($urandom); memRdy[i] = 1'($urandom);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         for (int i = 0; i < NDUT; i++) begin
            checks++;
            if ({memA[i], q[i], busy[i], memRd[i], done[i], err[i]} !== 20'd0) begin
               errors++;
               $display("[TB] FAIL reset dut%0d cyc%0d: memA=%h Q=%h busy/rd/done/err=%b%b%b%b required all 0",
                        i, c, memA[i], q[i], busy[i], memRd[i], done[i], err[i]);
            end
            addr[i] = 8'($urandom); memD[i] = 8'($urandom); memRdy[i] = 1'($urandom);
         end
      end
      for (int i = 0; i < NDUT; i++) begin
         res[i] = 1'b0; start[i] = 1'b0; lastQ[i] = 8'h00;
      end
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         checks++;
         if (busy[i] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle dut%0d: busy=%b required 0", i, busy[i]);
         end
      end
   endtask

   // WAIT=1, addr 3C, data A5, ready throughout: done exactly at edge k+3.
   task automatic test_single_read();
      logic [4:0] expBusy, expRd, expDone;
      logic [7:0] prevQ, expQ;
      expBusy = 5'b00111; expRd = 5'b00110; expDone = 5'b01000;
      prevQ = lastQ[0];
      @(negedge clk);
      start[0] = 1'b1; addr[0] = 8'h3C; memD[0] = 8'hA5; memRdy[0] = 1'b1;
      for (int m = 0; m < 5; m++) begin
         @(negedge clk);
         start[0] = 1'b0; addr[0] = 8'($urandom);
         expQ = (m >= 3) ? 8'hA5 : prevQ;
         checks++;
         if (memA[0] !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL single_mem_a m=%0d: got %h required 3c", m, memA[0]);
         end
         checks++;
         if ({busy[0], memRd[0], done[0], err[0]} !== {expBusy[m], expRd[m], expDone[m], 1'b0}) begin
            errors++;
            $display("[TB] FAIL single_ctl m=%0d: busy/rd/done/err got %b%b%b%b required %b%b%b0",
                     m, busy[0], memRd[0], done[0], err[0], expBusy[m], expRd[m], expDone[m]);
         end
         checks++;
         if (q[0] !== expQ) begin
            errors++;
            $display("[TB] FAIL single_q m=%0d: got %h required %h", m, q[0], expQ);
         end
      end
      lastQ[0] = 8'hA5;
   endtask

   // WAIT=0, three stall cycles in SAMPLE, ready also high (ignored) during ADDR.
   task automatic test_stall();
      logic [6:0] expBusy, expRd, expDone;
      logic [7:0] prevQ, expQ;
      int e;
      expBusy = 7'b0011111; expRd = 7'b0011110; expDone = 7'b0100000;
      prevQ = lastQ[1];
      @(negedge clk);
      start[1] = 1'b1; addr[1] = 8'hC3; memD[1] = 8'h00; memRdy[1] = 1'b1;
      for (int m = 0; m < 7; m++) begin
         @(negedge clk);
         expQ = (m >= 5) ? 8'h5A : prevQ;
         checks++;
         if ({busy[1], memRd[1], done[1], err[1]} !== {expBusy[m], expRd[m], expDone[m], 1'b0}) begin
            errors++;
            $display("[TB] FAIL stall_ctl m=%0d: busy/rd/done/err got %b%b%b%b required %b%b%b0",
                     m, busy[1], memRd[1], done[1], err[1], expBusy[m], expRd[m], expDone[m]);
         end
         checks++;
         if (q[1] !== expQ) begin
            errors++;
            $display("[TB] FAIL stall_q m=%0d: got %h required %h", m, q[1], expQ);
         end
         e = m + 1;
         start[1] = 1'b0;
         memRdy[1] = !(e >= 2 && e <= 4);
         memD[1] = (e == 5) ? 8'h5A : 8'($urandom);
      end
      lastQ[1] = 8'h5A;
   endtask

   // WAIT=1: start during WAIT is ignored; start in the done cycle launches the next read.
   task automatic test_back_to_back();
      logic [8:0] startBits, expBusy, expRd, expDone;
      logic [7:0] prevQ, expQ, expA;
      int e;
      startBits = 9'b000010101;
      expBusy = 9'b001110111; expRd = 9'b001100110; expDone = 9'b010001000;
      prevQ = lastQ[0];
      @(negedge clk);
      start[0] = 1'b1; addr[0] = 8'h10; memD[0] = 8'h11; memRdy[0] = 1'b1;
      for (int m = 0; m < 9; m++) begin
         @(negedge clk);
         expA = (m < 4) ? 8'h10 : 8'h20;
         expQ = (m < 3) ? prevQ : ((m < 7) ? 8'h11 : 8'h22);
         checks++;
         if (memA[0] !== expA) begin
            errors++;
            $display("[TB] FAIL b2b_mem_a m=%0d: got %h required %h", m, memA[0], expA);
         end
         checks++;
         if ({busy[0], memRd[0], done[0], err[0]} !== {expBusy[m], expRd[m], expDone[m], 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_ctl m=%0d: busy/rd/done/err got %b%b%b%b required %b%b%b0",
                     m, busy[0], memRd[0], done[0], err[0], expBusy[m], expRd[m], expDone[m]);
         end
         checks++;
         if (q[0] !== expQ) begin
            errors++;
            $display("[TB] FAIL b2b_q m=%0d: got %h required %h", m, q[0], expQ);
         end
         e = m + 1;
         start[0] = (e < 9) ? startBits[e] : 1'b0;
         addr[0] = 8'h20;
         memD[0] = (e <= 3) ? 8'h11 : 8'h22;
      end
      lastQ[0] = 8'h22;
   endtask

   // WAIT=3: reset lands in the middle of the wait states; the read is dropped.
   task automatic test_reset_mid_wait();
      @(negedge clk);
      start[2] = 1'b1; addr[2] = 8'h4B; memD[2] = 8'($urandom); memRdy[2] = 1'b1;
      @(negedge clk);
      start[2] = 1'b0;
      checks++;
      if ({busy[2], memRd[2], done[2]} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL midwait_edge0: busy/rd/done got %b%b%b required 100", busy[2], memRd[2], done[2]);
      end
      @(negedge clk);
      checks++;
      if ({busy[2], memRd[2], done[2]} !== 3'b110) begin
         errors++;
         $display("[TB] FAIL midwait_edge1: busy/rd/done got %b%b%b required 110", busy[2], memRd[2], done[2]);
      end
      res[2] = 1'b1;
      @(negedge clk);
      res[2] = 1'b0;
      checks++;
      if ({memA[2], q[2], busy[2], memRd[2], done[2], err[2]} !== 20'd0) begin
         errors++;
         $display("[TB] FAIL midwait_reset: memA=%h Q=%h busy/rd/done/err=%b%b%b%b required all 0",
                  memA[2], q[2], busy[2], memRd[2], done[2], err[2]);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if ({q[2], busy[2], memRd[2], done[2], err[2]} !== 12'd0) begin
            errors++;
            $display("[TB] FAIL midwait_after c=%0d: Q=%h busy/rd/done/err=%b%b%b%b required all 0",
                     c, q[2], busy[2], memRd[2], done[2], err[2]);
         end
      end
      lastQ[2] = 8'h00;
   endtask

   // Random reads on random instances with random stalls, stray starts and stray ready/data.
   task automatic test_random();
      int u, w, s, lastM, e;
      logic [7:0] a, d, prevQ, expQ;
      logic eBusy, eRd, eDone;
      for (int n = 0; n < 15; n++) begin
         u = int'($urandom_range(0, NDUT - 1));
         w = WAITS[u];
         s = int'($urandom_range(0, 6));
         a = 8'($urandom); d = 8'($urandom);
         lastM = 2 + w + s;
         prevQ = lastQ[u];
         @(negedge clk);
         start[u] = 1'b1; addr[u] = a; memRdy[u] = 1'($urandom); memD[u] = 8'($urandom);
         for (int m = 0; m <= lastM; m++) begin
            @(negedge clk);
            eBusy = (m <= lastM - 1);
            eRd   = (m >= 1 && m <= lastM - 1);
            eDone = (m == lastM);
            expQ  = (m == lastM) ? d : prevQ;
            checks++;
            if (memA[u] !== a) begin
               errors++;
               $display("[TB] FAIL rand_mem_a n=%0d dut%0d m=%0d: got %h required %h", n, u, m, memA[u], a);
            end
            checks++;
            if ({busy[u], memRd[u], done[u], err[u]} !== {eBusy, eRd, eDone, 1'b0}) begin
               errors++;
               $display("[TB] FAIL rand_ctl n=%0d dut%0d m=%0d: busy/rd/done/err got %b%b%b%b required %b%b%b0",
                        n, u, m, busy[u], memRd[u], done[u], err[u], eBusy, eRd, eDone);
            end
            checks++;
            if (q[u] !== expQ) begin
               errors++;
               $display("[TB] FAIL rand_q n=%0d dut%0d m=%0d: got %h required %h", n, u, m, q[u], expQ);
            end
            e = m + 1;
            start[u] = (m < lastM) ? 1'($urandom) : 1'b0;
            addr[u] = 8'($urandom);
            if (e < 2 + w) begin
               memRdy[u] = 1'($urandom); memD[u] = 8'($urandom);
            end else if (e < lastM) begin
               memRdy[u] = 1'b0; memD[u] = 8'($urandom);
            end else if (e == lastM) begin
               memRdy[u] = 1'b1; memD[u] = d;
            end else begin
               memRdy[u] = 1'($urandom); memD[u] = 8'($urandom);
            end
         end
         start[u] = 1'b0;
         lastQ[u] = d;
      end
   endtask

`ifdef MEM_RD_TIMEOUT_EN
   // WAIT=1: 16 stalls abort with err and keep Q; ready on the 16th stall cycle wins instead.
   task automatic test_timeout();
      logic [7:0] expQ;
      logic eBusy, eRd, eDone, eErr;
      @(negedge clk);
      start[0] = 1'b1; addr[0] = 8'h61; memD[0] = 8'h77; memRdy[0] = 1'b1;
      for (int m = 0; m < 4; m++) begin
         @(negedge clk);
         start[0] = 1'b0;
      end
      checks++;
      if (q[0] !== 8'h77) begin
         errors++;
         $display("[TB] FAIL timeout_preload: Q=%h required 77", q[0]);
      end
      for (int v = 0; v < 2; v++) begin
         @(negedge clk);
         start[0] = 1'b1; addr[0] = 8'($urandom); memRdy[0] = 1'b0; memD[0] = 8'($urandom);
         for (int m = 0; m <= 20; m++) begin
            @(negedge clk);
            eBusy = (m <= 17);
            eRd   = (m >= 1 && m <= 17);
            eDone = (v == 1 && m == 18);
            eErr  = (v == 0 && m == 18);
            expQ  = (v == 1 && m >= 18) ? 8'h99 : 8'h77;
            checks++;
            if ({busy[0], memRd[0], done[0], err[0]} !== {eBusy, eRd, eDone, eErr}) begin
               errors++;
               $display("[TB] FAIL timeout_ctl v=%0d m=%0d: busy/rd/done/err got %b%b%b%b required %b%b%b%b",
                        v, m, busy[0], memRd[0], done[0], err[0], eBusy, eRd, eDone, eErr);
            end
            checks++;
            if (q[0] !== expQ) begin
               errors++;
               $display("[TB] FAIL timeout_q v=%0d m=%0d: got %h required %h", v, m, q[0], expQ);
            end
            start[0] = 1'b0;
            memRdy[0] = (v == 1 && m + 1 == 18);
            memD[0] = (m + 1 == 18) ? 8'h99 : 8'($urandom);
         end
      end
      lastQ[0] = 8'h99;
   endtask
`endif

   initial begin
      for (int i = 0; i < NDUT; i++) begin
         res[i] = 1'b0; start[i] = 1'b0; addr[i] = 8'h00;
         memD[i] = 8'h00; memRdy[i] = 1'b0; lastQ[i] = 8'h00;
      end
      test_reset();
      test_single_read();
      test_stall();
      test_back_to_back();
      test_reset_mid_wait();
      test_random();
`ifdef MEM_RD_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
